// File: rtl/boss_danmaku.sv
// Boss bullet-pattern engine: NB bullet slots fired in volleys from the boss origin.
// Latency: volley spawns PERIOD+1 ticks after entering COOL; positions/hit update one tick after inputs.
// Backpressure: none; free-running game tick, bullets simply fail to spawn when every slot is busy.
// Ports: clk22/rst (sync, active-high); boss/gamestart clear the block; mode selects fan/aimed/bounce;
//        bossx/bossy = volley origin; reimux/reimuy = player centre; alive/bx/by = packed slot state;
//        hit = registered collision pulse; hit_count = saturating hit counter.
module boss_danmaku #(
    parameter int NB     = 8,
    parameter int W      = 10,
    parameter int PERIOD = 24,
    parameter int DY     = 8,
    parameter int DXU    = 3,
    parameter int XMIN   = 30,
    parameter int XMAX   = 410,
    parameter int YMIN   = 8,
    parameter int YMAX   = 472,
    parameter int HR     = 11
) (
    input  logic            clk22,
    input  logic            rst,
    input  logic            boss,
    input  logic            gamestart,
    input  logic [1:0]      mode,
    input  logic [W-1:0]    bossx,
    input  logic [W-1:0]    bossy,
    input  logic [W-1:0]    reimux,
    input  logic [W-1:0]    reimuy,
    output logic [NB-1:0]   alive,
    output logic [NB*W-1:0] bx,
    output logic [NB*W-1:0] by,
    output logic            hit,
    output logic [7:0]      hit_count
);

    typedef enum logic [1:0] {IDLE, COOL, VOLLEY} state_t;

    // Bounds held at W+1 bits so they compare directly against the carry-extended next position.
    localparam logic [W:0]   XLO  = (W+1)'(XMIN);
    localparam logic [W:0]   XHI  = (W+1)'(XMAX);
    localparam logic [W:0]   YLO  = (W+1)'(YMIN);
    localparam logic [W:0]   YHI  = (W+1)'(YMAX);
    localparam logic [W:0]   DYW  = (W+1)'(DY);
    localparam logic [W-1:0] HRW  = W'(HR);
    localparam logic signed [4:0] DXU5 = 5'(DXU);

    state_t         state;
    logic [7:0]     cnt;
    logic           clr;
    logic           volley;
    logic [NB-1:0]  coll;
    logic [W-1:0]   spawn_y;
    logic signed [4:0] aim_dx;

    assign clr     = rst | gamestart | ~boss;
    assign volley  = (state == VOLLEY);
    assign spawn_y = bossy + W'(16);

    always_comb begin
        aim_dx = '0;
        if (reimux > bossx)
            aim_dx = DXU5;
        else if (reimux < bossx)
            aim_dx = -DXU5;
    end

    // Sequencer plus the hit pulse/counter. !boss clears everything except hit_count.
    always_ff @(posedge clk22) begin
        if (clr) begin
            state <= IDLE;
            cnt   <= '0;
            hit   <= 1'b0;
            if (rst | gamestart)
                hit_count <= '0;
        end else begin
            hit <= |coll;
            if ((|coll) && (hit_count != 8'hFF))
                hit_count <= hit_count + 8'd1;
            case (state)
                IDLE: begin
                    state <= COOL;
                    cnt   <= '0;
                end
                COOL: begin
                    if (cnt == 8'(PERIOD - 1))
                        state <= VOLLEY;
                    else
                        cnt <= cnt + 8'd1;
                end
                VOLLEY: begin
                    cnt   <= '0;
                    state <= COOL;
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    for (genvar i = 0; i < NB; i++) begin : g_slot
        localparam logic signed [4:0] FAN = 5'((i % 5 - 2) * DXU);

        logic              on;
        logic              bnc;
        logic [W-1:0]      x;
        logic [W-1:0]      y;
        logic signed [4:0] d;
        logic [W:0]        nx;
        logic [W:0]        ny;
        logic [W-1:0]      ax;
        logic [W-1:0]      ay;

        // One extra bit catches wrap past 0 or 2^W; the sign-extended step handles negative dx.
        assign nx = {1'b0, x} + {{(W-4){d[4]}}, d};
        assign ny = {1'b0, y} + DYW;

        // Larger-minus-smaller so the distance never wraps.
        assign ax = (x > reimux) ? (x - reimux) : (reimux - x);
        assign ay = (y > reimuy) ? (y - reimuy) : (reimuy - y);
        assign coll[i] = on && (ax < HRW) && (ay < HRW);

        always_ff @(posedge clk22) begin
            if (clr) begin
                on  <= 1'b0;
                bnc <= 1'b0;
                x   <= bossx;
                y   <= bossy;
                d   <= '0;
            end else if (on) begin
                // Collision outranks exit and bounce; a dead slot keeps its last position.
                if (coll[i]) begin
                    on <= 1'b0;
                end else if (nx[W] || ny[W] || (ny < YLO) || (ny > YHI)) begin
                    on <= 1'b0;
                end else if ((nx < XLO) || (nx > XHI)) begin
                    if (bnc) begin
                        x <= (nx < XLO) ? XLO[W-1:0] : XHI[W-1:0];
                        y <= ny[W-1:0];
                        d <= -d;
                    end else begin
                        on <= 1'b0;
                    end
                end else begin
                    x <= nx[W-1:0];
                    y <= ny[W-1:0];
                end
            end else if (volley) begin
                // Only slots already dead at the start of the volley tick respawn.
                on  <= 1'b1;
                x   <= bossx;
                y   <= spawn_y;
                d   <= (mode == 2'd1) ? aim_dx : FAN;
                bnc <= (mode == 2'd2);
            end
        end

        assign alive[i]       = on;
        assign bx[i*W +: W]   = x;
        assign by[i*W +: W]   = y;
    end

endmodule

// File: tb/tb_boss_danmaku.sv
module tb_boss_danmaku;

    localparam int NB = 8;
    localparam int W  = 10;

    logic            clk22;
    logic            rst;
    logic            boss;
    logic            gamestart;
    logic [1:0]      mode;
    logic [W-1:0]    bossx;
    logic [W-1:0]    bossy;
    logic [W-1:0]    reimux;
    logic [W-1:0]    reimuy;
    logic [NB-1:0]   alive;
    logic [NB*W-1:0] bx;
    logic [NB*W-1:0] by;
    logic            hit;
    logic [7:0]      hit_count;

    boss_danmaku #(.NB(NB), .W(W), .PERIOD(4)) dut (
        .clk22     (clk22),
        .rst       (rst),
        .boss      (boss),
        .gamestart (gamestart),
        .mode      (mode),
        .bossx     (bossx),
        .bossy     (bossy),
        .reimux    (reimux),
        .reimuy    (reimuy),
        .alive     (alive),
        .bx        (bx),
        .by        (by),
        .hit       (hit),
        .hit_count (hit_count)
    );

    initial clk22 = 1'b0;
    always #5 clk22 = ~clk22;

    typedef struct {
        logic        rst;
        logic        boss;
        logic [1:0]  mode;
        logic [9:0]  ox, oy, px, py;
        int          sl;
        logic [7:0]  e_alive;
        logic        e_hit;
        logic [7:0]  e_hc;
        logic [9:0]  ex, ey;
    } vec_t;

    vec_t vq[$];
    int   nvec = 0;
    int   nbad = 0;

    logic [1:0] s_mode;
    logic [9:0] s_ox, s_oy, s_px, s_py;

    task automatic env(input int ox, input int oy, input int px, input int py, input int m);
        s_ox = 10'(ox); s_oy = 10'(oy); s_px = 10'(px); s_py = 10'(py); s_mode = 2'(m);
    endtask

    task automatic add(input logic r, input logic b, input int sl, input logic [7:0] a,
                       input logic h, input int hc, input int ex, input int ey);
        vec_t v;
        v.rst = r; v.boss = b; v.mode = s_mode;
        v.ox = s_ox; v.oy = s_oy; v.px = s_px; v.py = s_py;
        v.sl = sl; v.e_alive = a; v.e_hit = h; v.e_hc = 8'(hc);
        v.ex = 10'(ex); v.ey = 10'(ey);
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nbad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    initial begin
        vec_t v;
        logic [9:0] gx, gy;
        int hits;

        rst = 1'b1; boss = 1'b0; gamestart = 1'b0; mode = 2'd0;
        bossx = '0; bossy = '0; reimux = '0; reimuy = '0;

        // Fan volley, multi-slot collision near the player, boss drop and recovery.
        env(220, 100, 220, 140, 0);
        add(1, 0, 0, 8'h00, 0, 0, 220, 100);
        for (int k = 0; k < 5; k++) add(0, 1, 0, 8'h00, 0, 0, 220, 100);
        add(0, 1, 0, 8'hFF, 0, 0, 220, 116);
        add(0, 1, 0, 8'hFF, 0, 0, 214, 124);
        add(0, 1, 2, 8'hFF, 0, 0, 220, 132);
        add(0, 1, 2, 8'h31, 1, 1, 220, 132);
        add(0, 1, 0, 8'h31, 0, 1, 196, 148);
        add(0, 1, 4, 8'hFF, 0, 1, 250, 156);
        add(0, 0, 0, 8'h00, 0, 1, 220, 100);
        for (int k = 0; k < 5; k++) add(0, 1, 0, 8'h00, 0, 1, 220, 100);
        add(0, 1, 0, 8'hFF, 0, 1, 220, 116);

        // Bounce off the right wall.
        env(400, 100, 0, 0, 2);
        add(1, 0, 4, 8'h00, 0, 0, 400, 100);
        for (int k = 0; k < 5; k++) add(0, 1, 4, 8'h00, 0, 0, 400, 100);
        add(0, 1, 4, 8'hFF, 0, 0, 400, 116);
        add(0, 1, 4, 8'hFF, 0, 0, 406, 124);
        add(0, 1, 4, 8'hFF, 0, 0, 410, 132);
        add(0, 1, 4, 8'hFF, 0, 0, 404, 140);

        // Same geometry in fan mode: slots exit instead of bouncing, then respawn.
        env(400, 100, 0, 0, 0);
        add(1, 0, 4, 8'h00, 0, 0, 400, 100);
        for (int k = 0; k < 5; k++) add(0, 1, 4, 8'h00, 0, 0, 400, 100);
        add(0, 1, 4, 8'hFF, 0, 0, 400, 116);
        add(0, 1, 4, 8'hFF, 0, 0, 406, 124);
        add(0, 1, 4, 8'hEF, 0, 0, 406, 124);
        add(0, 1, 3, 8'hEF, 0, 0, 409, 140);
        add(0, 1, 3, 8'hE7, 0, 0, 409, 140);
        add(0, 1, 4, 8'hFF, 0, 0, 400, 116);

        // Aimed straight down, exit past YMAX, respawn on next volley.
        env(220, 440, 220, 0, 1);
        add(1, 0, 0, 8'h00, 0, 0, 220, 440);
        for (int k = 0; k < 5; k++) add(0, 1, 0, 8'h00, 0, 0, 220, 440);
        add(0, 1, 0, 8'hFF, 0, 0, 220, 456);
        add(0, 1, 4, 8'hFF, 0, 0, 220, 464);
        add(0, 1, 0, 8'hFF, 0, 0, 220, 472);
        add(0, 1, 0, 8'h00, 0, 0, 220, 472);
        add(0, 1, 0, 8'h00, 0, 0, 220, 472);
        add(0, 1, 0, 8'hFF, 0, 0, 220, 456);

        // Aimed right; the direction is latched at spawn even after the player moves left.
        env(220, 100, 300, 0, 1);
        add(1, 0, 0, 8'h00, 0, 0, 220, 100);
        for (int k = 0; k < 5; k++) add(0, 1, 0, 8'h00, 0, 0, 220, 100);
        add(0, 1, 0, 8'hFF, 0, 0, 220, 116);
        add(0, 1, 0, 8'hFF, 0, 0, 223, 124);
        env(220, 100, 100, 0, 1);
        add(0, 1, 0, 8'hFF, 0, 0, 226, 132);

        for (int k = 0; k < vq.size(); k++) begin
            v = vq[k];
            rst = v.rst; boss = v.boss; gamestart = 1'b0; mode = v.mode;
            bossx = v.ox; bossy = v.oy; reimux = v.px; reimuy = v.py;
            @(posedge clk22);
            #1;
            gx = bx[v.sl*W +: W];
            gy = by[v.sl*W +: W];
            nvec++;
            if (alive !== v.e_alive || hit !== v.e_hit || hit_count !== v.e_hc ||
                gx !== v.ex || gy !== v.ey) begin
                nbad++;
                $display("FAIL vec%0d: alive=%h hit=%b hc=%0d slot%0d=(%0d,%0d) expected alive=%h hit=%b hc=%0d (%0d,%0d)",
                         k, alive, hit, hit_count, v.sl, gx, gy,
                         v.e_alive, v.e_hit, v.e_hc, v.ex, v.ey);
            end
        end

        // Player sits on the spawn point: every volley produces one all-slot collision.
        rst = 1'b1; boss = 1'b0; mode = 2'd0;
        bossx = 10'd220; bossy = 10'd100; reimux = 10'd220; reimuy = 10'd116;
        @(posedge clk22);
        #1;
        rst = 1'b0; boss = 1'b1;
        hits = 0;
        for (int n = 0; n < 1300; n++) begin
            @(posedge clk22);
            #1;
            if (hit === 1'b1) hits++;
            if (n == 6) begin
                chk("first_hit_pulse", int'(hit), 1);
                chk("first_hit_count", int'(hit_count), 1);
                chk("all_slots_despawn", int'(alive), 0);
            end
            if (n == 7) chk("hit_one_cycle", int'(hit), 0);
        end
        chk("hit_pulses", hits, 259);
        chk("hit_count_saturated", int'(hit_count), 255);

        gamestart = 1'b1;
        @(posedge clk22);
        #1;
        chk("gamestart_clears_count", int'(hit_count), 0);
        chk("gamestart_clears_alive", int'(alive), 0);
        gamestart = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
